spi_register_controller: RTL and testbench

//  Sequences the SPI secondary shift engine into a register-access protocol for the motion backend.

---
 rtl/spi_register_controller_if.sv | 79 +++++++
 rtl/spi_register_controller.sv | 215 +++++++++++++++++++++
 tb/tb_spi_register_controller.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_register_controller_if.sv
`default_nettype none
//==============================================================================
// Module      : spi_register_controller_if
// Description : Bundles the SPI-secondary word handshake and the internal
//               register-bus handshake seen by spi_register_controller.
//
//   SPI side (from/to the SPI secondary shift engine)
//     neg_enable  chip select, active low, already synchronised to clk
//     word_ready  one-clk pulse, rx_word holds a complete received word
//     rx_word     word just received
//     tx_word     word to shift out in the next word slot
//   Register-bus side
//     reg_addr    register address
//     reg_wdata   register write data (WORD_BITS*DATA_WORDS wide)
//     reg_we      one-clk write strobe
//     reg_re      one-clk read strobe
//     reg_rdata   read data, valid while reg_ack=1
//     reg_ack     read-data-valid pulse
//   Status
//     busy        controller is not idle
//     err         sticky protocol error
//
//   Modports: slave  = the controller itself
//             master = the environment driving it (SPI engine + register file)
//
// Revision    : 1.0  initial release
//==============================================================================
interface spi_register_controller_if #(
    parameter int WORD_BITS  = 8,
    parameter int ADDR_BITS  = 6,
    parameter int DATA_WORDS = 4
);
    localparam int c_REG_BITS = WORD_BITS * DATA_WORDS;

    logic                  neg_enable;
    logic                  word_ready;
    logic [WORD_BITS-1:0]  rx_word;
    logic [WORD_BITS-1:0]  tx_word;
    logic [ADDR_BITS-1:0]  reg_addr;
    logic [c_REG_BITS-1:0] reg_wdata;
    logic                  reg_we;
    logic                  reg_re;
    logic [c_REG_BITS-1:0] reg_rdata;
    logic                  reg_ack;
    logic                  busy;
    logic                  err;

    modport slave (
        input  neg_enable,
        input  word_ready,
        input  rx_word,
        input  reg_rdata,
        input  reg_ack,
        output tx_word,
        output reg_addr,
        output reg_wdata,
        output reg_we,
        output reg_re,
        output busy,
        output err
    );

    modport master (
        output neg_enable,
        output word_ready,
        output rx_word,
        output reg_rdata,
        output reg_ack,
        input  tx_word,
        input  reg_addr,
        input  reg_wdata,
        input  reg_we,
        input  reg_re,
        input  busy,
        input  err
    );

endinterface
`default_nettype wire

// File: rtl/spi_register_controller.sv
`default_nettype none
//==============================================================================
// Module      : spi_register_controller
// Description : Turns the word stream of an SPI secondary into register-bus
//               accesses. The first word of a frame is a command:
//                 bit[WORD_BITS-1]   1 = write, 0 = read
//                 bits[ADDR_BITS-1:0] start address
//               Writes collect DATA_WORDS words (most significant first) and
//               emit one reg_we per group, auto-incrementing the address.
//               Reads issue reg_re, wait for reg_ack, then present the read
//               data MSW first on tx_word, auto-incrementing for bursts.
//               Deasserting chip select returns to idle from any state.
//
//   Ports
//     clk   in   system clock
//     rst   in   asynchronous, active-high reset
//     bus   slave modport of spi_register_controller_if (SPI word
//           handshake, register bus, busy/err status)
//
// Revision    : 1.0  initial release
//==============================================================================
module spi_register_controller #(
    parameter int WORD_BITS  = 8,   // must be >= ADDR_BITS+1
    parameter int ADDR_BITS  = 6,
    parameter int DATA_WORDS = 4
) (
    input  wire                         clk,
    input  wire                         rst,
    spi_register_controller_if.slave    bus
);

    localparam int c_REG_BITS = WORD_BITS * DATA_WORDS;
    localparam int c_CNT_BITS = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;
    localparam logic [c_CNT_BITS-1:0] c_LAST_CNT = c_CNT_BITS'(DATA_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_WR_DATA = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_RD_DATA = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [c_CNT_BITS-1:0]   r_cnt;
    logic [ADDR_BITS-1:0]    r_addr;
    logic [c_REG_BITS-1:0]   r_wdata;
    logic [c_REG_BITS-1:0]   r_tx_buf;
    logic                    r_we;
    logic                    r_re;
    logic                    r_err;

    // Control decoded by the next-state logic, consumed by the datapath.
    logic                    w_last;       // current word closes a group
    logic                    w_cmd_latch;  // command word accepted
    logic                    w_wr_shift;   // write data word accepted
    logic                    w_rd_shift;   // read data word consumed
    logic                    w_load_tx;    // read data captured from reg bus
    logic                    w_issue_we;   // write strobe next clk
    logic                    w_issue_re;   // read strobe next clk
    logic                    w_set_err;    // protocol error seen

    assign w_last = (r_cnt == c_LAST_CNT);

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and control decode
    //--------------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_cmd_latch  = 1'b0;
        w_wr_shift   = 1'b0;
        w_rd_shift   = 1'b0;
        w_load_tx    = 1'b0;
        w_issue_we   = 1'b0;
        w_issue_re   = 1'b0;
        w_set_err    = 1'b0;

        if (bus.neg_enable) begin
            // Chip select released: everything pending is dropped, and a
            // word_ready arriving in the same clk is deliberately ignored.
            w_next_state = ST_IDLE;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_next_state = ST_CMD;
                end

                ST_CMD: begin
                    if (bus.word_ready) begin
                        w_cmd_latch = 1'b1;
                        if (bus.rx_word[WORD_BITS-1]) begin
                            w_next_state = ST_WR_DATA;
                        end else begin
                            w_next_state = ST_RD_WAIT;
                            w_issue_re   = 1'b1;
                        end
                    end
                end

                ST_WR_DATA: begin
                    if (bus.word_ready) begin
                        w_wr_shift = 1'b1;
                        w_issue_we = w_last;
                    end
                end

                ST_RD_WAIT: begin
                    // The master clocked a word out before data was ready:
                    // flag the underrun. An ack in the same clk still wins.
                    if (bus.word_ready) begin
                        w_set_err = 1'b1;
                    end
                    if (bus.reg_ack) begin
                        w_load_tx    = 1'b1;
                        w_next_state = ST_RD_DATA;
                    end
                end

                ST_RD_DATA: begin
                    if (bus.word_ready) begin
                        w_rd_shift = 1'b1;
                        if (w_last) begin
                            w_issue_re   = 1'b1;
                            w_next_state = ST_RD_WAIT;
                        end
                    end
                end

                default: begin
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    //--------------------------------------------------------------------------
    // Datapath
    //--------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_tx_buf <= '0;
            r_we     <= 1'b0;
            r_re     <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we <= w_issue_we;
            r_re <= w_issue_re;

            // Word counter: restarts on every new frame, command or read fetch.
            if ((r_state == ST_IDLE) || w_cmd_latch || w_load_tx) begin
                r_cnt <= '0;
            end else if (w_wr_shift || w_rd_shift) begin
                r_cnt <= w_last ? '0 : r_cnt + c_CNT_BITS'(1);
            end

            // Address: a write advances only after its strobe cycle so the
            // register file sees the original address with reg_we; a read
            // advances together with issuing the next reg_re.
            if (w_cmd_latch) begin
                r_addr <= bus.rx_word[ADDR_BITS-1:0];
            end else if (r_we || (w_rd_shift && w_last)) begin
                r_addr <= r_addr + ADDR_BITS'(1);
            end

            if (w_wr_shift) begin
                r_wdata <= (r_wdata << WORD_BITS) | c_REG_BITS'(bus.rx_word);
            end

            if (w_load_tx) begin
                r_tx_buf <= bus.reg_rdata;
            end else if (w_rd_shift) begin
                r_tx_buf <= r_tx_buf << WORD_BITS;
            end

            // Sticky until the next command word; survives chip-select release.
            if (w_cmd_latch) begin
                r_err <= 1'b0;
            end else if (w_set_err) begin
                r_err <= 1'b1;
            end
        end
    end

    //--------------------------------------------------------------------------
    // Outputs
    //--------------------------------------------------------------------------
    // Only RD_DATA has valid read data to offer; everywhere else (including
    // an underrun in RD_WAIT) the secondary shifts out zeros.
    assign bus.tx_word   = (r_state == ST_RD_DATA) ? r_tx_buf[c_REG_BITS-1 -: WORD_BITS]
                                                   : '0;
    assign bus.reg_addr  = r_addr;
    assign bus.reg_wdata = r_wdata;
    assign bus.reg_we    = r_we;
    assign bus.reg_re    = r_re;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_register_controller.sv
`default_nettype none
//==============================================================================
// Module      : tb_spi_register_controller
// Description : Directed self-checking bench for spi_register_controller.
//               Strobes are captured by a monitor into queues and compared
//               against hand-computed addresses and data.
// Revision    : 1.0  initial release
//==============================================================================
module tb_spi_register_controller;

    localparam int WORD_BITS  = 8;
    localparam int ADDR_BITS  = 6;
    localparam int DATA_WORDS = 4;

    logic clk;
    logic rst;

    int n_checks = 0;
    int n_errors = 0;
    int n_bad    = 0;   // strobe-rule violations seen by the monitor

    logic [37:0] we_q[$];   // {addr, wdata}
    logic [5:0]  re_q[$];   // addr
    logic [37:0] e_we;
    logic [5:0]  e_re;

    spi_register_controller_if #(
        .WORD_BITS (WORD_BITS),
        .ADDR_BITS (ADDR_BITS),
        .DATA_WORDS(DATA_WORDS)
    ) bus_if ();

    spi_register_controller #(
        .WORD_BITS (WORD_BITS),
        .ADDR_BITS (ADDR_BITS),
        .DATA_WORDS(DATA_WORDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Strobe monitor on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (bus_if.reg_we === 1'b1) we_q.push_back({bus_if.reg_addr, bus_if.reg_wdata});
        if (bus_if.reg_re === 1'b1) re_q.push_back(bus_if.reg_addr);
        if ((bus_if.reg_we === 1'b1) && (bus_if.reg_re === 1'b1)) n_bad++;
        if (((bus_if.reg_we === 1'b1) || (bus_if.reg_re === 1'b1)) && (bus_if.busy !== 1'b1)) n_bad++;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One word slot: a single-clk word_ready followed by an idle clk.
    task automatic send(input logic [7:0] w);
        bus_if.word_ready = 1'b1;
        bus_if.rx_word    = w;
        tick();
        bus_if.word_ready = 1'b0;
        tick();
    endtask

    task automatic cs_high();
        bus_if.neg_enable = 1'b1;
        tick();
        tick();
    endtask

    task automatic cs_low();
        bus_if.neg_enable = 1'b0;
        tick();
    endtask

    initial begin
        rst               = 1'b1;
        bus_if.neg_enable = 1'b1;
        bus_if.word_ready = 1'b0;
        bus_if.rx_word    = '0;
        bus_if.reg_rdata  = '0;
        bus_if.reg_ack    = 1'b0;
        tick();
        tick();

        // ---------------- reset state
        check("rst_busy",  bus_if.busy,      0);
        check("rst_err",   bus_if.err,       0);
        check("rst_tx",    bus_if.tx_word,   0);
        check("rst_we",    bus_if.reg_we,    0);
        check("rst_re",    bus_if.reg_re,    0);
        check("rst_addr",  bus_if.reg_addr,  0);
        check("rst_wdata", bus_if.reg_wdata, 0);
        rst = 1'b0;
        tick();
        check("idle_busy", bus_if.busy, 0);

        // ---------------- single write 0xDEADBEEF to 0x05
        cs_low();
        check("cmd_busy", bus_if.busy, 1);
        send(8'h85);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        check("wr_none_early", we_q.size(), 0);
        send(8'hEF);
        check("wr_cnt", we_q.size(), 1);
        if (we_q.size() > 0) begin
            e_we = we_q.pop_front();
            check("wr_addr", e_we[37:32], 6'h05);
            check("wr_data", e_we[31:0],  32'hDEADBEEF);
        end
        check("wr_tx_zero",  bus_if.tx_word,  0);
        check("wr_addr_inc", bus_if.reg_addr, 6'h06);
        check("wr_no_re",    re_q.size(),     0);
        cs_high();
        check("wr_end_busy", bus_if.busy, 0);

        // ---------------- read 0x03, ack two clks after reg_re, then burst
        cs_low();
        bus_if.word_ready = 1'b1;
        bus_if.rx_word    = 8'h03;
        tick();                              // reg_re now high
        bus_if.word_ready = 1'b0;
        check("rd_re_now", bus_if.reg_re, 1);
        tick();
        tick();
        bus_if.reg_ack   = 1'b1;
        bus_if.reg_rdata = 32'h12345678;
        tick();
        bus_if.reg_ack   = 1'b0;
        bus_if.reg_rdata = '0;
        check("rd_tx0", bus_if.tx_word, 8'h12);
        send(8'h00);
        check("rd_tx1", bus_if.tx_word, 8'h34);
        send(8'h00);
        check("rd_tx2", bus_if.tx_word, 8'h56);
        send(8'h00);
        check("rd_tx3", bus_if.tx_word, 8'h78);
        check("rd_err", bus_if.err, 0);
        send(8'h00);                         // 4th word -> next fetch
        check("rd_tx_wait", bus_if.tx_word, 0);
        check("rd_re_cnt", re_q.size(), 2);
        if (re_q.size() > 1) begin
            e_re = re_q.pop_front();
            check("rd_re_addr0", e_re, 6'h03);
            e_re = re_q.pop_front();
            check("rd_re_addr1", e_re, 6'h04);
        end

        // ---------------- underrun in RD_WAIT, then ack+word_ready together
        send(8'h00);
        check("ur_err", bus_if.err,     1);
        check("ur_tx",  bus_if.tx_word, 0);
        check("ur_busy", bus_if.busy,   1);
        bus_if.word_ready = 1'b1;
        bus_if.reg_ack    = 1'b1;
        bus_if.reg_rdata  = 32'hCAFEF00D;
        tick();
        bus_if.word_ready = 1'b0;
        bus_if.reg_ack    = 1'b0;
        bus_if.reg_rdata  = '0;
        check("both_tx",  bus_if.tx_word, 8'hCA);
        check("both_err", bus_if.err,     1);
        cs_high();
        check("ur_idle_busy", bus_if.busy, 0);
        check("ur_err_held",  bus_if.err,  1);
        bus_if.reg_ack   = 1'b1;            // stray ack while idle
        bus_if.reg_rdata = 32'hFFFFFFFF;
        tick();
        bus_if.reg_ack   = 1'b0;
        bus_if.reg_rdata = '0;
        check("idle_ack_tx", bus_if.tx_word, 0);

        // ---------------- new command clears err; abort a partial write
        cs_low();
        send(8'h85);
        check("cmd_clr_err", bus_if.err, 0);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        bus_if.word_ready = 1'b1;            // last word coincides with cs rising
        bus_if.rx_word    = 8'h04;
        bus_if.neg_enable = 1'b1;
        tick();
        bus_if.word_ready = 1'b0;
        check("abort_busy", bus_if.busy, 0);
        tick();
        tick();
        check("abort_no_we", we_q.size(), 0);
        cs_low();
        check("restart_busy", bus_if.busy, 1);
        send(8'h87);
        send(8'h0A);
        send(8'h0B);
        send(8'h0C);
        send(8'h0D);
        check("restart_cnt", we_q.size(), 1);
        if (we_q.size() > 0) begin
            e_we = we_q.pop_front();
            check("restart_addr", e_we[37:32], 6'h07);
            check("restart_data", e_we[31:0],  32'h0A0B0C0D);
        end
        cs_high();

        // ---------------- burst write with address wrap 0x3F -> 0x00
        cs_low();
        send(8'hBF);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        send(8'h55); send(8'h66); send(8'h77); send(8'h88);
        check("burst_cnt", we_q.size(), 2);
        if (we_q.size() > 1) begin
            e_we = we_q.pop_front();
            check("burst_addr0", e_we[37:32], 6'h3F);
            check("burst_data0", e_we[31:0],  32'h11223344);
            e_we = we_q.pop_front();
            check("burst_addr1", e_we[37:32], 6'h00);
            check("burst_data1", e_we[31:0],  32'h55667788);
        end
        check("burst_no_re", re_q.size(), 0);
        cs_high();

        // ---------------- async reset while waiting for read data
        cs_low();
        send(8'h02);
        check("ar_busy_pre", bus_if.busy, 1);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("ar_busy",  bus_if.busy,      0);
        check("ar_addr",  bus_if.reg_addr,  0);
        check("ar_wdata", bus_if.reg_wdata, 0);
        check("ar_re",    bus_if.reg_re,    0);
        check("ar_tx",    bus_if.tx_word,   0);
        tick();
        bus_if.reg_ack   = 1'b1;
        bus_if.reg_rdata = 32'hA5A5A5A5;
        rst = 1'b0;
        tick();
        bus_if.reg_ack   = 1'b0;
        bus_if.reg_rdata = '0;
        tick();
        check("ar_late_ack_tx", bus_if.tx_word, 0);
        check("ar_in_cmd",      bus_if.busy,    1);
        check("ar_re_cnt", re_q.size(), 1);
        if (re_q.size() > 0) begin
            e_re = re_q.pop_front();
            check("ar_re_addr", e_re, 6'h02);
        end
        cs_high();

        check("strobe_rules", n_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
